// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a FIFO (slave) and its drain stage (master).
interface fifo_uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();

    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data;

    // Drain stage: issues pops, consumes empty flag and registered data_out.
    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_data
    );

    // FIFO side: accepts pops, presents empty flag and data_out.
    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_data
    );

endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word, sends it LSB byte first as 8N1 UART frames.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit (8E1 frames).
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic [15:0]    words_sent
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned BAUD_W    = $clog2(CLKS_PER_BIT);

    // Elaboration-time parameter sanity checks.
    generate
        if (DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
            $error("fifo_uart_tx: DATA_WIDTH must be a nonzero multiple of 8");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, POP, LOAD, START, DATA, PARITY, STOP
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE, POP, LOAD, START, DATA, STOP
    } state_e;
`endif

    state_e                state_q,  state_d;
    logic [BAUD_W-1:0]     baud_q,   baud_d;
    logic [2:0]            bit_q,    bit_d;
    logic [BYTE_W-1:0]     byte_q,   byte_d;
    logic [DATA_WIDTH-1:0] shreg_q,  shreg_d;
    logic                  tx_q,     tx_d;
    logic                  rd_en_q,  rd_en_d;
    logic                  busy_q,   busy_d;
    logic [15:0]           words_q,  words_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic last_baud_c;
    logic last_byte_c;

    assign last_baud_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_byte_c = (byte_q == BYTE_W'(NUM_BYTES - 1));

    // Next-state and registered-output decode; tx_d reflects the state being entered.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BAUD_W'(1);
        bit_d    = bit_q;
        byte_d   = byte_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        rd_en_d  = 1'b0;
        words_d  = words_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo.fifo_empty) begin
                    state_d = POP;
                    rd_en_d = 1'b1;
                end
            end
            POP: begin
                baud_d  = '0;
                state_d = LOAD;
            end
            LOAD: begin
                baud_d   = '0;
                shreg_d  = fifo.fifo_data;
                byte_d   = '0;
                bit_d    = 3'd0;
                tx_d     = 1'b0;
                state_d  = START;
`ifdef UART_TX_PARITY_EN
                parity_d = 1'b0;
`endif
            end
            START: begin
                if (last_baud_c) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last_baud_c) begin
                    baud_d   = '0;
                    shreg_d  = shreg_q >> 1;
`ifdef UART_TX_PARITY_EN
                    parity_d = parity_q ^ shreg_q[0];
`endif
                    if (bit_q != 3'd7) begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shreg_q[1];
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q ^ shreg_q[0];
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last_baud_c) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (last_baud_c) begin
                    baud_d = '0;
                    if (!last_byte_c) begin
                        byte_d   = byte_q + BYTE_W'(1);
                        bit_d    = 3'd0;
                        tx_d     = 1'b0;
                        state_d  = START;
`ifdef UART_TX_PARITY_EN
                        parity_d = 1'b0;
`endif
                    end else begin
                        words_d = words_q + 16'd1;
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            byte_q   <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            words_q  <= 16'd0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            rd_en_q  <= rd_en_d;
            busy_q   <= busy_d;
            words_q  <= words_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign fifo.fifo_rd_en = rd_en_q;
    assign tx              = tx_q;
    assign busy            = busy_q;
    assign words_sent      = words_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: bench FIFO model, UART receive monitor.
module tb_fifo_uart_tx;

    localparam int unsigned DW       = 16;
    localparam int unsigned CPB      = 4;
    localparam int unsigned NB       = DW / 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB       = 11;
`else
    localparam int unsigned FB       = 10;
`endif
    localparam int unsigned WORD_CYC = NB * FB * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx;
    logic        busy;
    logic [15:0] words_sent;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) dif ();

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo      (dif.master),
        .tx        (tx),
        .busy      (busy),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_par_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bench FIFO: registered data_out and empty flag.
    always @(posedge clk) begin
        if (dif.fifo_rd_en) begin
            checks++;
            if (mem_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_underflow: pop while FIFO empty at %0t", $time);
            end else begin
                dif.fifo_data <= mem_q.pop_front();
            end
        end
        dif.fifo_empty <= (mem_q.size() == 0);
    end

    // Pop-pulse monitor: single-cycle pulses, minimum spacing between words.
    int   cyc      = 0;
    int   last_pop = -1;
    logic prev_rd  = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last_pop = -1;
        end else if (dif.fifo_rd_en === 1'b1) begin
            chk("pop_single_cycle", 32'(prev_rd), 32'd0);
            if (last_pop >= 0)
                chk("pop_gap_min", 32'(cyc - last_pop >= int'(WORD_CYC) + 1), 32'd1);
            last_pop = cyc;
        end
        prev_rd = dif.fifo_rd_en;
    end

    // UART receive monitor: mid-bit sampling, word reassembly, scoreboard compare.
    int            rx_cnt;
    int            rx_j;
    bit            rx_act = 1'b0;
    int            rx_nb  = 0;
    logic [7:0]    rx_byte;
    logic [DW-1:0] rx_word;
    always @(negedge clk) begin
        if (rst) begin
            rx_act = 1'b0;
            rx_nb  = 0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % CPB) == CPB / 2) begin
                rx_j = rx_cnt / CPB;
                if (rx_j == 0) begin
                    chk("rx_start_bit", 32'(tx), 32'd0);
                end else if (rx_j <= 8) begin
                    rx_byte[rx_j-1] = tx;
`ifdef UART_TX_PARITY_EN
                end else if (rx_j == 9) begin
                    chk("rx_parity_bit", 32'(tx), 32'(^rx_byte));
                    if (exp_par_q.size() > 0)
                        chk("rx_parity_hand", 32'(tx), 32'(exp_par_q.pop_front()));
`endif
                end else begin
                    chk("rx_stop_bit", 32'(tx), 32'd1);
                    rx_act = 1'b0;
                    rx_word[8*rx_nb +: 8] = rx_byte;
                    rx_nb++;
                    if (rx_nb == int'(NB)) begin
                        rx_nb = 0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_word: unexpected word 0x%0h, none pending", rx_word);
                        end else begin
                            chk("rx_word", 32'(rx_word), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [DW-1:0] w);
        mem_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_words(input logic [15:0] tgt, input int budget, input string nm);
        int n = 0;
        while (words_sent !== tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(words_sent), 32'(tgt));
    endtask

    task automatic wait_pop(input string nm);
        int n = 0;
        while (dif.fifo_rd_en !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(dif.fifo_rd_en), 32'd1);
    endtask

    logic [DW-1:0] b2b_words [8] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8001,
                                     16'hBEEF, 16'h7E81, 16'h00FF, 16'hC35A};
    logic [15:0]   exp_words;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_rd_en", 32'(dif.fifo_rd_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_words", 32'(words_sent), 32'd0);
        rst = 1'b0;

        // Idle with empty FIFO.
        repeat (50) begin
            @(negedge clk);
            chk("idle_tx", 32'(tx), 32'd1);
            chk("idle_rd_en", 32'(dif.fifo_rd_en), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_words", 32'(words_sent), 32'd0);
        end

        // Single word: latency, pulse width, frame length.
        push_word(16'hA55A);
        @(negedge clk);
        chk("w1_empty_fell", 32'(dif.fifo_empty), 32'd0);
        @(negedge clk);
        chk("w1_rd_en_hi", 32'(dif.fifo_rd_en), 32'd1);
        chk("w1_tx_idle_pop", 32'(tx), 32'd1);
        @(negedge clk);
        chk("w1_rd_en_lo", 32'(dif.fifo_rd_en), 32'd0);
        chk("w1_tx_idle_load", 32'(tx), 32'd1);
        @(negedge clk);
        chk("w1_tx_start", 32'(tx), 32'd0);
        chk("w1_busy", 32'(busy), 32'd1);
        repeat (WORD_CYC - 1) @(negedge clk);
        chk("w1_busy_last_stop", 32'(busy), 32'd1);
        chk("w1_tx_last_stop", 32'(tx), 32'd1);
        @(negedge clk);
        chk("w1_busy_fall", 32'(busy), 32'd0);
        chk("w1_words", 32'(words_sent), 32'd1);
        exp_words = 16'd1;
        repeat (5) @(negedge clk);

        // Back-to-back: eight queued words.
        for (int i = 0; i < 8; i++) push_word(b2b_words[i]);
        exp_words = exp_words + 16'd8;
        wait_words(exp_words, 8 * (WORD_CYC + 10) + 50, "b2b_words");
        repeat (3) @(negedge clk);
        chk("b2b_fifo_empty", 32'(dif.fifo_empty), 32'd1);
        chk("b2b_all_received", 32'(exp_q.size()), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd0);

        // Reset during data bit 3 of the second byte.
        push_word(16'h3C96);
        push_word(16'h1234);
        wait_pop("rst_pop_seen");
        repeat (2 + FB * CPB + 4 * CPB + 1) @(negedge clk);
        chk("rst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx_high", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_words", 32'(words_sent), 32'd0);
        chk("rst_rd_en", 32'(dif.fifo_rd_en), 32'd0);
        void'(exp_q.pop_front());
        rst = 1'b0;
        exp_words = 16'd1;
        wait_words(exp_words, 2 * WORD_CYC + 50, "rst_next_word");
        repeat (3) @(negedge clk);
        chk("rst_all_received", 32'(exp_q.size()), 32'd0);

        // Counter wrap.
        force dut.words_q = 16'hFFFF;
        @(negedge clk);
        release dut.words_q;
        @(negedge clk);
        chk("wrap_preset", 32'(words_sent), 32'hFFFF);
        push_word(16'h00FF);
        wait_words(16'h0000, 2 * WORD_CYC + 50, "wrap_words");

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 and 0x01 each carry parity 1.
        repeat (3) @(negedge clk);
        push_word(16'h0107);
        exp_par_q.push_back(1'b1);
        exp_par_q.push_back(1'b1);
        wait_words(16'h0001, 2 * WORD_CYC + 50, "parity_words");
        repeat (3) @(negedge clk);
        chk("parity_all_checked", 32'(exp_par_q.size()), 32'd0);
`endif

        repeat (5) @(negedge clk);
        chk("final_all_received", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
